// File: rtl/conv_mac_array.sv
// Bank of LANES signed fixed-point MAC lanes sharing one broadcast weight per beat.
// Each TAPS-beat window is reduced through bias, half-up rounding, saturation and optional ReLU.
module conv_mac_array #(
  parameter int LANES = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACCW  = 40,
  parameter int TAPS  = 25
) (
  input  logic                  clk,
  input  logic                  globalReset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   pixels,
  input  logic [DW-1:0]         weight,
  input  logic [DW-1:0]         bias,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   column
);

  localparam int CW = $clog2(TAPS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Bias at output scale, add half an LSB, floor-shift, clamp to DW, then optional ReLU.
  function automatic logic [DW-1:0] sat_round(
    input logic signed [ACCW-1:0] acc,
    input logic        [DW-1:0]   b,
    input logic                   relu
  );
    logic signed [ACCW-1:0] b_ext;
    logic signed [ACCW-1:0] s;
    logic signed [ACCW-1:0] r;
    logic        [DW-1:0]   o;
    b_ext = {{(ACCW-DW){b[DW-1]}}, b};
    s = acc + (b_ext <<< FRAC) + (ACCW'(1) <<< (FRAC - 1));
    r = s >>> FRAC;
    if (r > MAX_V) begin
      o = MAX_V[DW-1:0];
    end else if (r < MIN_V) begin
      o = MIN_V[DW-1:0];
    end else begin
      o = r[DW-1:0];
    end
    if (relu && o[DW-1]) begin
      o = {DW{1'b0}};
    end else begin
      o = o;
    end
    return o;
  endfunction

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      relu_q, relu_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;
  logic [LANES*DW-1:0]       column_q, column_d;
  logic signed [ACCW-1:0]    acc_q [LANES];
  logic signed [ACCW-1:0]    acc_d [LANES];

  logic signed [2*DW-1:0]    pix_ext_s [LANES];
  logic signed [2*DW-1:0]    wt_ext_s;
  logic signed [2*DW-1:0]    prod_s    [LANES];
  logic signed [ACCW-1:0]    fin_acc_s [LANES];
  logic [LANES*DW-1:0]       res_s;
  logic                      relu_eff_s;
  logic                      last_beat_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign column    = column_q;

  // Per-lane products; the first beat of a window overwrites rather than accumulates.
  always_comb begin
    res_s      = {(LANES*DW){1'b0}};
    wt_ext_s   = {{DW{weight[DW-1]}}, weight};
    relu_eff_s = (state_q == S_IDLE) ? relu_en : relu_q;
    for (int i = 0; i < LANES; i++) begin
      pix_ext_s[i] = {{DW{pixels[i*DW+DW-1]}}, pixels[i*DW +: DW]};
      prod_s[i]    = pix_ext_s[i] * wt_ext_s;
      if (state_q == S_IDLE) begin
        fin_acc_s[i] = {{(ACCW-2*DW){prod_s[i][2*DW-1]}}, prod_s[i]};
      end else begin
        fin_acc_s[i] = acc_q[i] + {{(ACCW-2*DW){prod_s[i][2*DW-1]}}, prod_s[i]};
      end
      res_s[i*DW +: DW] = sat_round(fin_acc_s[i], bias, relu_eff_s);
    end
  end

  // Window sequencing: IDLE takes the first tap, ACCUM the rest, OUT holds the column.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    column_d    = column_q;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
    end
    if (state_q == S_IDLE) begin
      last_beat_s = (TAPS == 1);
    end else begin
      last_beat_s = (cnt_q == CW'(TAPS - 1));
    end
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
              acc_d[i] = fin_acc_s[i];
            end
            if (state_q == S_IDLE) begin
              relu_d = relu_en;
              cnt_d  = CW'(1);
            end else begin
              relu_d = relu_q;
              cnt_d  = cnt_q + CW'(1);
            end
            if (last_beat_s) begin
              state_d     = S_OUT;
              cnt_d       = {CW{1'b0}};
              out_valid_d = 1'b1;
              column_d    = res_s;
            end else begin
              state_d = S_ACCUM;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = S_OUT;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          cnt_d       = {CW{1'b0}};
        end
      endcase
    end
    in_ready_d = (state_d != S_OUT);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      column_q    <= {(LANES*DW){1'b0}};
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= {ACCW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      column_q    <= column_d;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  conv_mac_array_chk #(.CWID(LANES*DW)) u_chk (
    .clk       (clk),
    .rst_n     (globalReset),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .column    (column)
  );

endmodule

// Handshake invariants: ready and valid are mutually exclusive, and a pending column stays put.
module conv_mac_array_chk #(
  parameter int CWID = 160
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  input logic            in_ready,
  input logic            out_valid,
  input logic            out_ready,
  input logic [CWID-1:0] column
);

  a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n) in_ready != out_valid);

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(column)));

endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array at TAPS=4: a table of uniform-pixel windows plus
// hand-written sequences for lane ordering, backpressure, stalls, flush and async reset.
module tb_conv_mac_array;

  localparam int LANES = 10;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACCW  = 40;
  localparam int TAPS  = 4;
  localparam int CWID  = LANES * DW;

  logic            clk = 1'b0;
  logic            globalReset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CWID-1:0] pixels = '0;
  logic [DW-1:0]   weight = '0;
  logic [DW-1:0]   bias = '0;
  logic            relu_en = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CWID-1:0] column;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string               name;
    logic [3:0][DW-1:0]  pix;
    logic [3:0][DW-1:0]  wt;
    logic [DW-1:0]       bias;
    logic                relu;
    logic [DW-1:0]       exp;
  } vec_t;

  vec_t vecs[12];

  conv_mac_array #(
    .LANES(LANES), .DW(DW), .FRAC(FRAC), .ACCW(ACCW), .TAPS(TAPS)
  ) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pixels      (pixels),
    .weight      (weight),
    .bias        (bias),
    .relu_en     (relu_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .column      (column)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CWID-1:0] act, input logic [CWID-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [CWID-1:0] bcast(input logic [DW-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [3:0][DW-1:0] mk4(input logic [DW-1:0] b0, b1, b2, b3);
    logic [3:0][DW-1:0] r;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
    return r;
  endfunction

  // One accepted beat; called and returns at a falling edge.
  task automatic beat(input logic [CWID-1:0] p, input logic [DW-1:0] w, input logic [DW-1:0] b,
                      input logic r);
    pixels = p; weight = w; bias = b; relu_en = r; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic take_result(input string name, input logic [CWID-1:0] exp);
    chk({name, "_valid"}, CWID'(out_valid), CWID'(1));
    chk({name, "_col"}, column, exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_drop"}, CWID'(out_valid), CWID'(0));
    chk({name, "_rdy"}, CWID'(in_ready), CWID'(1));
  endtask

  // Four beats with junk bias on non-last beats and inverted relu after the first beat.
  task automatic window(input string name, input logic [3:0][DW-1:0] pix, input logic [3:0][DW-1:0] wt,
                        input logic [DW-1:0] b, input logic r, input logic [DW-1:0] exp);
    for (int k = 0; k < 4; k++) begin
      beat(bcast(pix[k]), wt[k], (k == 3) ? b : 16'h5A5A, (k == 0) ? r : ~r);
      if (k == 2) chk({name, "_early"}, CWID'(out_valid), CWID'(0));
    end
    take_result(name, bcast(exp));
  endtask

  initial begin
    logic [CWID-1:0] lane_pix;
    logic [CWID-1:0] lane_exp;

    vecs[0]  = '{"basic",      mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk4(16'h0080, 16'h0080, 16'h0080, 16'h0080), 16'h0000, 1'b0, 16'h0200};
    vecs[1]  = '{"bias_round", mk4(16'h0001, 16'h0001, 16'h0001, 16'h0001), mk4(16'h0080, 16'h0000, 16'h0000, 16'h0000), 16'h0100, 1'b0, 16'h0101};
    vecs[2]  = '{"sat_pos",    mk4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), mk4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h0000, 1'b0, 16'h7FFF};
    vecs[3]  = '{"neg",        mk4(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00), mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0000, 1'b0, 16'hFC00};
    vecs[4]  = '{"neg_relu",   mk4(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00), mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{"pos_relu",   mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk4(16'h0080, 16'h0080, 16'h0080, 16'h0080), 16'h0000, 1'b1, 16'h0200};
    vecs[6]  = '{"sat_neg",    mk4(16'h8000, 16'h8000, 16'h8000, 16'h8000), mk4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h0000, 1'b0, 16'h8000};
    vecs[7]  = '{"rnd_nzero",  mk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), mk4(16'h0080, 16'h0000, 16'h0000, 16'h0000), 16'h0000, 1'b0, 16'h0000};
    vecs[8]  = '{"rnd_none",   mk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), mk4(16'h0081, 16'h0000, 16'h0000, 16'h0000), 16'h0000, 1'b0, 16'hFFFF};
    vecs[9]  = '{"sat_edge",   mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk4(16'h7FFF, 16'h0001, 16'h0000, 16'h0000), 16'h0000, 1'b0, 16'h7FFF};
    vecs[10] = '{"bias_neg",   mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100), mk4(16'h0080, 16'h0080, 16'h0080, 16'h0080), 16'hFF00, 1'b0, 16'h0100};
    vecs[11] = '{"mixed_wt",   mk4(16'h0200, 16'h0200, 16'h0200, 16'h0200), mk4(16'h0100, 16'hFF80, 16'h0040, 16'h0000), 16'h0000, 1'b0, 16'h0180};

    #12;
    chk("rst_valid", CWID'(out_valid), CWID'(0));
    chk("rst_col", column, CWID'(0));
    chk("rst_rdy", CWID'(in_ready), CWID'(1));
    @(negedge clk);
    globalReset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      window(vecs[v].name, vecs[v].pix, vecs[v].wt, vecs[v].bias, vecs[v].relu, vecs[v].exp);
    end

    // Lane ordering: lane i carries (i-5).0, weight 0.25 over four beats -> (i-5).0
    for (int i = 0; i < LANES; i++) begin
      lane_pix[i*DW +: DW] = DW'((i - 5) * 256);
      lane_exp[i*DW +: DW] = DW'((i - 5) * 256);
    end
    for (int k = 0; k < 4; k++) beat(lane_pix, 16'h0040, 16'h0000, 1'b0);
    take_result("lanes", lane_exp);

    // Backpressure: result held while upstream keeps offering beats
    for (int k = 0; k < 4; k++) beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      pixels = bcast(16'h1111); weight = 16'h0100; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_rdy", CWID'(in_ready), CWID'(0));
      chk("bp_col", column, bcast(16'h0200));
    end
    in_valid = 1'b0;
    take_result("bp", bcast(16'h0200));
    window("after_bp", vecs[0].pix, vecs[0].wt, 16'h0000, 1'b0, 16'h0200);

    // Stalls between beats
    beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    idle_cycles(2);
    beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    idle_cycles(1);
    beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    idle_cycles(3);
    chk("stall_early", CWID'(out_valid), CWID'(0));
    beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    take_result("stall", bcast(16'h0200));

    // Flush after two beats, with a beat offered in the flush cycle
    beat(bcast(16'h7FFF), 16'h7FFF, 16'h0000, 1'b0);
    beat(bcast(16'h7FFF), 16'h7FFF, 16'h0000, 1'b0);
    pixels = bcast(16'h7FFF); in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    window("flush_acc", vecs[0].pix, vecs[0].wt, 16'h0000, 1'b0, 16'h0200);

    // Flush with a beat while idle: that beat must not count as the first tap
    pixels = bcast(16'h0100); weight = 16'h0080; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    window("flush_idle", vecs[0].pix, vecs[0].wt, 16'h0000, 1'b0, 16'h0200);

    // Flush racing out_ready discards the result
    for (int k = 0; k < 4; k++) beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    chk("fout_valid", CWID'(out_valid), CWID'(1));
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("fout_drop", CWID'(out_valid), CWID'(0));
    chk("fout_rdy", CWID'(in_ready), CWID'(1));

    // Asynchronous reset mid-window, between clock edges
    beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    beat(bcast(16'h0100), 16'h0080, 16'h0000, 1'b0);
    #2;
    globalReset = 1'b0;
    #1;
    chk("arst_valid", CWID'(out_valid), CWID'(0));
    chk("arst_col", column, CWID'(0));
    chk("arst_rdy", CWID'(in_ready), CWID'(1));
    @(negedge clk);
    globalReset = 1'b1;
    window("after_rst", vecs[11].pix, vecs[11].wt, 16'h0000, 1'b0, 16'h0180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
